// File: rtl/raz_sequencer.sv
// External RAZ sequencer: on an accepted trigger rising edge, wait a programmable delay,
// drive a RAZ pulse of programmable width, then hold off before re-arming.
module raz_sequencer #(
    parameter int unsigned DELAY_W = 4,
    parameter int unsigned HOLD_W  = 8,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               Clk,
    input  logic               reset_n,
    input  logic               ExternalRaz_en,
    input  logic               Trig_in,
    input  logic [DELAY_W-1:0] RazDelayTime,
    input  logic [DELAY_W-1:0] RazWidth,
    input  logic [HOLD_W-1:0]  HoldoffTime,
    input  logic               CountClear,
    output logic               RazPulse,
    output logic               Busy,
    output logic [CNT_W-1:0]   AcceptCount,
    output logic [CNT_W-1:0]   MissedCount
);

    localparam int unsigned CntW = (HOLD_W > DELAY_W) ? HOLD_W : DELAY_W;

    typedef enum logic [1:0] {StIdle, StDelay, StPulse, StHoldoff} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [DELAY_W-1:0] width_q, width_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               trig_q;
    logic               raz_q, raz_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   accept_q, accept_d;
    logic [CNT_W-1:0]   missed_q, missed_d;
    logic               rise;
    logic               accept_inc;
    logic               missed_inc;

    assign rise = Trig_in & ~trig_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        width_d    = width_q;
        hold_d     = hold_q;
        accept_inc = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rise && ExternalRaz_en) begin
                    accept_inc = 1'b1;
                    width_d    = RazWidth;
                    hold_d     = HoldoffTime;
                    if (RazDelayTime != '0) begin
                        state_d = StDelay;
                        cnt_d   = CntW'(RazDelayTime) - CntW'(1);
                    end else begin
                        state_d = StPulse;
                        cnt_d   = CntW'(RazWidth);
                    end
                end
            end
            StDelay: begin
                if (!ExternalRaz_en) begin
                    state_d = StIdle;
                end else if (cnt_q == '0) begin
                    state_d = StPulse;
                    cnt_d   = CntW'(width_q);
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            // The pulse always runs to completion so Trig_Gen never sees a runt.
            StPulse: begin
                if (cnt_q == '0) begin
                    if (hold_q != '0) begin
                        state_d = StHoldoff;
                        cnt_d   = CntW'(hold_q) - CntW'(1);
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StHoldoff: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign missed_inc = rise && ExternalRaz_en && (state_q != StIdle);

    // Outputs lag the state by one cycle so the pulse starts at edge N+1+D.
    always_comb begin
        raz_d  = (state_q == StPulse);
        busy_d = (state_q != StIdle);
    end

    always_comb begin
        accept_d = accept_q;
        missed_d = missed_q;
        if (CountClear) begin
            accept_d = '0;
            missed_d = '0;
        end else begin
            if (accept_inc && (accept_q != '1)) accept_d = accept_q + CNT_W'(1);
            if (missed_inc && (missed_q != '1)) missed_d = missed_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            width_q  <= '0;
            hold_q   <= '0;
            trig_q   <= 1'b0;
            raz_q    <= 1'b0;
            busy_q   <= 1'b0;
            accept_q <= '0;
            missed_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            width_q  <= width_d;
            hold_q   <= hold_d;
            trig_q   <= Trig_in;
            raz_q    <= raz_d;
            busy_q   <= busy_d;
            accept_q <= accept_d;
            missed_q <= missed_d;
        end
    end

    assign RazPulse    = raz_q;
    assign Busy        = busy_q;
    assign AcceptCount = accept_q;
    assign MissedCount = missed_q;

endmodule

// File: tb/tb_raz_sequencer.sv
// Directed bench for raz_sequencer; a second instance with 2-bit counters exercises saturation.
module tb_raz_sequencer;

    logic       Clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       en = 1'b0;
    logic       trig = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] dly = '0;
    logic [3:0] wid = '0;
    logic [7:0] hold = '0;

    logic        rz, busy;
    logic [15:0] acc, mis;
    logic        s_rz, s_busy;
    logic [1:0]  s_acc, s_mis;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    raz_sequencer #(.DELAY_W(4), .HOLD_W(8), .CNT_W(16)) dut (
        .Clk(Clk), .reset_n(reset_n), .ExternalRaz_en(en), .Trig_in(trig),
        .RazDelayTime(dly), .RazWidth(wid), .HoldoffTime(hold), .CountClear(clr),
        .RazPulse(rz), .Busy(busy), .AcceptCount(acc), .MissedCount(mis)
    );

    raz_sequencer #(.DELAY_W(4), .HOLD_W(8), .CNT_W(2)) dut_sat (
        .Clk(Clk), .reset_n(reset_n), .ExternalRaz_en(en), .Trig_in(trig),
        .RazDelayTime(dly), .RazWidth(wid), .HoldoffTime(hold), .CountClear(clr),
        .RazPulse(s_rz), .Busy(s_busy), .AcceptCount(s_acc), .MissedCount(s_mis)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        trig = 1'b0;
        clr = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(1);
    endtask

    task automatic cfg(input logic [3:0] d, input logic [3:0] w, input logic [7:0] h);
        dly = d;
        wid = w;
        hold = h;
    endtask

    // Rise is sampled at the next edge (edge N); returns just after edge N.
    task automatic fire;
        trig = 1'b1;
        tick(1);
        trig = 1'b0;
    endtask

    initial begin
        int nb, nr;

        // Reset state and basic D=3 W=1 H=0 sequence
        do_reset;
        check_eq("rst_rz", rz, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_acc", acc, 0);
        check_eq("rst_mis", mis, 0);
        en = 1'b1;
        cfg(3, 1, 0);
        tick(1);
        fire;
        for (int k = 1; k <= 7; k++) begin
            tick(1);
            check_eq($sformatf("t1_rz_%0d", k), rz, (k == 4 || k == 5));
            check_eq($sformatf("t1_busy_%0d", k), busy, (k <= 5));
        end
        check_eq("t1_acc", acc, 1);
        check_eq("t1_mis", mis, 0);

        // D=0 W=0 H=4 with a rise during holdoff
        do_reset;
        cfg(0, 0, 4);
        fire;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            check_eq($sformatf("t2_rz_%0d", k), rz, (k == 1));
            check_eq($sformatf("t2_busy_%0d", k), busy, (k <= 5));
            if (k == 2) trig = 1'b1;
            if (k == 3) trig = 1'b0;
        end
        check_eq("t2_acc", acc, 1);
        check_eq("t2_mis", mis, 1);

        // Enable loss during delay aborts without a pulse
        do_reset;
        cfg(10, 0, 0);
        fire;
        nr = 0;
        for (int k = 1; k <= 14; k++) begin
            tick(1);
            nr += int'(rz);
            check_eq($sformatf("t3_busy_%0d", k), busy, (k <= 3));
            if (k == 2) en = 1'b0;
        end
        check_eq("t3_nopulse", nr, 0);
        check_eq("t3_acc", acc, 1);
        en = 1'b1;

        // Enable loss during pulse does not shorten it
        do_reset;
        cfg(0, 5, 0);
        fire;
        for (int k = 1; k <= 9; k++) begin
            tick(1);
            check_eq($sformatf("t3b_rz_%0d", k), rz, (k >= 1 && k <= 6));
            if (k == 2) en = 1'b0;
        end
        en = 1'b1;

        // Config change after acceptance applies only to the next trigger
        do_reset;
        cfg(3, 0, 0);
        fire;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            check_eq($sformatf("t4a_rz_%0d", k), rz, (k == 4));
            if (k == 1) dly = 4'd9;
        end
        tick(2);
        fire;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            check_eq($sformatf("t4b_rz_%0d", k), rz, (k == 10));
        end
        check_eq("t4_acc", acc, 2);

        // Saturation on the 2-bit instance, clear priority, missed counting
        do_reset;
        cfg(0, 0, 0);
        repeat (2) begin
            fire;
            tick(2);
        end
        check_eq("t5_sat_acc_pre", s_acc, 2);
        repeat (3) begin
            fire;
            tick(2);
        end
        check_eq("t5_sat_acc", s_acc, 3);
        check_eq("t5_acc", acc, 5);
        trig = 1'b1;
        clr = 1'b1;
        tick(1);
        trig = 1'b0;
        clr = 1'b0;
        check_eq("t5_clr_acc", acc, 0);
        check_eq("t5_clr_sat_acc", s_acc, 0);
        tick(1);
        check_eq("t5_clr_pulse", rz, 1);
        tick(3);
        cfg(0, 0, 20);
        fire;
        repeat (4) begin
            tick(1);
            trig = 1'b1;
            tick(1);
            trig = 1'b0;
        end
        check_eq("t5_mis", mis, 4);
        check_eq("t5_sat_mis", s_mis, 3);
        check_eq("t5_acc2", acc, 1);
        tick(25);

        // Async reset mid-pulse
        do_reset;
        cfg(0, 5, 0);
        fire;
        tick(2);
        check_eq("t6_rz_pre", rz, 1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("t6_rz_async", rz, 0);
        check_eq("t6_busy_async", busy, 0);
        check_eq("t6_acc_async", acc, 0);
        #1 reset_n = 1'b1;
        tick(3);
        check_eq("t6_rz_post", rz, 0);
        check_eq("t6_busy_post", busy, 0);

        // Held trigger gives one event; disabled rise is not counted
        trig = 1'b1;
        tick(12);
        check_eq("t7_held_acc", acc, 1);
        check_eq("t7_held_mis", mis, 0);
        trig = 1'b0;
        tick(3);
        en = 1'b0;
        fire;
        tick(3);
        check_eq("t7_dis_acc", acc, 1);
        check_eq("t7_dis_mis", mis, 0);
        check_eq("t7_dis_busy", busy, 0);
        en = 1'b1;

        // All-max config: 15 + 16 + 255 busy cycles
        do_reset;
        cfg(15, 15, 255);
        fire;
        nb = 0;
        nr = 0;
        for (int k = 1; k <= 300; k++) begin
            tick(1);
            nb += int'(busy);
            nr += int'(rz);
        end
        check_eq("t8_busy_cycles", nb, 286);
        check_eq("t8_pulse_cycles", nr, 16);
        check_eq("t8_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
